// File: rtl/sram_controller_pkg.sv
// Shared types and widths for the data-memory SRAM controller.
package sram_controller_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOW  = 2'd1,
      S_HIGH = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam int SRAM_AW = 18;
   localparam int SRAM_DW = 16;

   localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

endpackage

// File: rtl/sram_controller.sv
// Serves one 32-bit MEM-stage load/store as two timed half-word accesses
// on a 16-bit asynchronous SRAM; ready stays low while an access is in flight.
module sram_controller
   import sram_controller_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               MEM_R_EN,
   input  logic               MEM_W_EN,
   input  logic [31:0]        address,
   input  logic [31:0]        writeData,
   output logic [31:0]        readData,
   output logic               ready,
   output logic [SRAM_AW-1:0] SRAM_ADDR,
   output logic [SRAM_DW-1:0] SRAM_DQ_out,
   input  logic [SRAM_DW-1:0] SRAM_DQ_in,
   output logic               SRAM_DQ_oe,
   output logic               SRAM_WE_N,
   output logic               SRAM_OE_N
);

   localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

   state_t               r_state;
   state_t               w_next;
   logic [3:0]           r_cnt;
   logic [16:0]          r_idx;
   logic [31:0]          r_wdata;
   logic                 r_write;
   logic [31:0]          r_rdata;
   logic [SRAM_AW-1:0]   r_sram_addr;
   logic [SRAM_DW-1:0]   r_dq_out;
   logic                 r_dq_oe;
   logic                 r_we_n;
   logic                 r_oe_n;

   logic                 w_req;
   logic [31:0]          w_offset;
   logic                 w_hold_done;
   logic                 w_active_next;
   logic [16:0]          w_idx;
   logic [31:0]          w_wdata;
   logic                 w_write;
   logic                 w_unused_bits;

   assign w_req         = MEM_R_EN | MEM_W_EN;
   assign w_offset      = address - BASE_ADDR;
   assign w_unused_bits = &{1'b0, w_offset[31:19], w_offset[1:0]};
   assign w_hold_done   = (r_cnt == LAST_CNT);
   assign w_active_next = (w_next == S_LOW) || (w_next == S_HIGH);

   // In IDLE the request is latched on the same edge that starts LOW, so the
   // first half's strobes are built straight from the inputs.
   assign w_idx   = (r_state == S_IDLE) ? w_offset[18:2] : r_idx;
   assign w_wdata = (r_state == S_IDLE) ? writeData      : r_wdata;
   assign w_write = (r_state == S_IDLE) ? MEM_W_EN       : r_write;

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (w_req)       w_next = S_LOW;
         S_LOW:   if (w_hold_done) w_next = S_HIGH;
         S_HIGH:  if (w_hold_done) w_next = S_DONE;
         S_DONE:                   w_next = S_IDLE;
         default:                  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= 4'd0;
         r_rdata     <= 32'd0;
         r_sram_addr <= '0;
         r_dq_out    <= '0;
         r_dq_oe     <= 1'b0;
         r_we_n      <= 1'b1;
         r_oe_n      <= 1'b1;
      end else begin
         r_state <= w_next;
         r_cnt   <= (w_next == r_state && (r_state == S_LOW || r_state == S_HIGH))
                    ? r_cnt + 4'd1 : 4'd0;

         if (r_state == S_IDLE && w_req) begin
            r_idx   <= w_offset[18:2];
            r_wdata <= writeData;
            r_write <= MEM_W_EN;
         end

         // Strobes are registered from the next state so address, data and
         // WE_N all change together at the start of each half.
         if (w_active_next) begin
            r_sram_addr <= {w_idx, (w_next == S_HIGH)};
            if (w_write)
               r_dq_out <= (w_next == S_HIGH) ? w_wdata[31:16] : w_wdata[15:0];
         end
         r_we_n  <= ~(w_active_next & w_write);
         r_oe_n  <= ~(w_active_next & ~w_write);
         r_dq_oe <= w_active_next & w_write;

         if (!r_write && w_hold_done) begin
            if (r_state == S_LOW)
               r_rdata[15:0] <= SRAM_DQ_in;
            else if (r_state == S_HIGH)
               r_rdata[31:16] <= SRAM_DQ_in;
         end
      end
   end

   assign ready       = ((r_state == S_IDLE) && !w_req) || (r_state == S_DONE);
   assign readData    = r_rdata;
   assign SRAM_ADDR   = r_sram_addr;
   assign SRAM_DQ_out = r_dq_out;
   assign SRAM_DQ_oe  = r_dq_oe;
   assign SRAM_WE_N   = r_we_n;
   assign SRAM_OE_N   = r_oe_n;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: table of load/store vectors on a WAIT_CYCLES=2 instance,
// hand sequences for back-to-back, reset mid-store and a WAIT_CYCLES=1 instance.
module tb_sram_controller;

   localparam int W0 = 2;
   localparam int W1 = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   logic        re0, we0, rdy0, oe0, wen0, oen0;
   logic [31:0] addr0, wd0, rd0;
   logic [17:0] sa0;
   logic [15:0] dqo0, dqi0;

   logic        re1, we1, rdy1, oe1, wen1, oen1;
   logic [31:0] addr1, wd1, rd1;
   logic [17:0] sa1;
   logic [15:0] dqo1, dqi1;

   sram_controller #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(W0)) dut0 (
      .clk(clk), .rst(rst), .MEM_R_EN(re0), .MEM_W_EN(we0), .address(addr0),
      .writeData(wd0), .readData(rd0), .ready(rdy0), .SRAM_ADDR(sa0),
      .SRAM_DQ_out(dqo0), .SRAM_DQ_in(dqi0), .SRAM_DQ_oe(oe0),
      .SRAM_WE_N(wen0), .SRAM_OE_N(oen0));

   sram_controller #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(W1)) dut1 (
      .clk(clk), .rst(rst), .MEM_R_EN(re1), .MEM_W_EN(we1), .address(addr1),
      .writeData(wd1), .readData(rd1), .ready(rdy1), .SRAM_ADDR(sa1),
      .SRAM_DQ_out(dqo1), .SRAM_DQ_in(dqi1), .SRAM_DQ_oe(oe1),
      .SRAM_WE_N(wen1), .SRAM_OE_N(oen1));

   // Behavioural SRAMs: combinational read; a write commits only once WE_N has
   // been held low on one address for the full wait time.
   logic [15:0] mem0 [0:262143];
   logic [15:0] mem1 [0:262143];
   assign dqi0 = mem0[sa0];
   assign dqi1 = mem1[sa1];

   int          hold_cnt0 = 0;
   logic [17:0] hold_addr0 = '0;
   always @(posedge clk) begin
      if (!wen0) begin
         if (sa0 == hold_addr0 && hold_cnt0 != 0) begin
            hold_cnt0 <= hold_cnt0 + 1;
            if (hold_cnt0 + 1 == W0) mem0[sa0] <= dqo0;
         end else begin
            hold_cnt0  <= 1;
            hold_addr0 <= sa0;
         end
      end else begin
         hold_cnt0 <= 0;
      end
   end

   int we_low_n = 0, oe_low_n = 0, drv_n = 0;
   always @(negedge clk) begin
      if (!wen0) we_low_n <= we_low_n + 1;
      if (!oen0) oe_low_n <= oe_low_n + 1;
      if (oe0)   drv_n    <= drv_n + 1;
   end

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        re;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      int          exp_lat;
   } vec_t;

   typedef struct {
      logic [31:0] rd;
      int          lat;
      logic        is_store;
   } exp_t;

   exp_t sb[$];

   // Called just after a rising edge with dut0 idle; returns just after the
   // edge that leaves DONE, with the request dropped.
   task automatic do_access(input string name, input vec_t v);
      exp_t e;
      int   lat, w_s, o_s, d_s;
      bit   got;
      e.rd = v.exp_rd; e.lat = v.exp_lat; e.is_store = v.we;
      sb.push_back(e);
      w_s = we_low_n; o_s = oe_low_n; d_s = drv_n;
      re0 = v.re; we0 = v.we; addr0 = v.addr; wd0 = v.wdata;
      lat = 0; got = 0;
      while (!got && lat < 40) begin
         @(posedge clk); lat++;
         @(negedge clk);
         if (rdy0) got = 1;
      end
      e = sb.pop_front();
      check({name, " ready"}, 32'(got), 32'd1);
      check({name, " latency"}, lat, e.lat);
      check({name, " readData"}, rd0, e.rd);
      @(posedge clk); #1;
      re0 = 0; we0 = 0;
      check({name, " WE_N low cycles"}, we_low_n - w_s, e.is_store ? 2*W0 : 0);
      check({name, " OE_N low cycles"}, oe_low_n - o_s, e.is_store ? 0 : 2*W0);
      check({name, " DQ_oe cycles"}, drv_n - d_s, e.is_store ? 2*W0 : 0);
   endtask

   vec_t vecs[8];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] m3;
      int          lat;
      bit          got;

      vecs[0] = '{re:0, we:1, addr:32'd1024, wdata:32'hDEADBEEF, exp_rd:32'h00000000, exp_lat:5};
      vecs[1] = '{re:1, we:0, addr:32'd1024, wdata:32'h0,        exp_rd:32'hDEADBEEF, exp_lat:5};
      vecs[2] = '{re:1, we:1, addr:32'd1040, wdata:32'h00000055, exp_rd:32'hDEADBEEF, exp_lat:5};
      vecs[3] = '{re:1, we:0, addr:32'd1040, wdata:32'h0,        exp_rd:32'h00000055, exp_lat:5};
      vecs[4] = '{re:0, we:1, addr:32'd1020, wdata:32'h0BADF00D, exp_rd:32'h00000055, exp_lat:5};
      vecs[5] = '{re:1, we:0, addr:32'd1020, wdata:32'h0,        exp_rd:32'h0BADF00D, exp_lat:5};
      vecs[6] = '{re:0, we:1, addr:32'd5024, wdata:32'h13579BDF, exp_rd:32'h0BADF00D, exp_lat:5};
      vecs[7] = '{re:1, we:0, addr:32'd5024, wdata:32'h0,        exp_rd:32'h13579BDF, exp_lat:5};

      mem1[4] = 16'h1234;
      mem1[5] = 16'hABCD;

      rst = 1; re0 = 0; we0 = 0; addr0 = 0; wd0 = 0;
      re1 = 0; we1 = 0; addr1 = 0; wd1 = 0;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      check("idle ready", 32'(rdy0), 32'd1);
      check("idle WE_N", 32'(wen0), 32'd1);
      check("idle OE_N", 32'(oen0), 32'd1);
      check("idle DQ_oe", 32'(oe0), 32'd0);
      check("idle readData", rd0, 32'd0);
      check("idle SRAM_ADDR", 32'(sa0), 32'd0);
      check("idle DQ_out", 32'(dqo0), 32'd0);
      check("idle ready w1", 32'(rdy1), 32'd1);
      @(posedge clk); #1;

      for (int i = 0; i < 8; i++)
         do_access($sformatf("vec%0d", i), vecs[i]);

      check("mem[0]", 32'(mem0[0]), 32'h0000BEEF);
      check("mem[1]", 32'(mem0[1]), 32'h0000DEAD);
      check("mem[8]", 32'(mem0[8]), 32'h00000055);
      check("mem[9]", 32'(mem0[9]), 32'h00000000);
      check("mem wrap lo", 32'(mem0[18'h3FFFE]), 32'h0000F00D);
      check("mem wrap hi", 32'(mem0[18'h3FFFF]), 32'h00000BAD);

      // Held load: DONE does not re-serve, the next access starts from IDLE.
      re0 = 1; addr0 = 32'd1024;
      lat = 0; got = 0;
      while (!got && lat < 40) begin
         @(posedge clk); lat++;
         @(negedge clk);
         if (rdy0) got = 1;
      end
      check("held first latency", lat, 5);
      @(posedge clk);
      @(negedge clk);
      check("held idle-with-request ready", 32'(rdy0), 32'd0);
      lat = 1; got = 0;
      while (!got && lat < 40) begin
         @(posedge clk); lat++;
         @(negedge clk);
         if (rdy0) got = 1;
      end
      check("held back-to-back period", lat, 2*W0 + 2);
      check("held readData", rd0, 32'hDEADBEEF);
      @(posedge clk); #1;
      re0 = 0;
      @(posedge clk); #1;

      // Reset pulsed during HIGH of a store to 1028.
      m3 = mem0[3];
      we0 = 1; addr0 = 32'd1028; wd0 = 32'hCAFE1234;
      repeat (3) @(posedge clk);
      #1;
      check("rst-mid HIGH address", 32'(sa0), 32'd3);
      check("rst-mid HIGH WE_N", 32'(wen0), 32'd0);
      check("rst-mid HIGH DQ_out", 32'(dqo0), 32'h0000CAFE);
      rst = 1; we0 = 0;
      @(posedge clk); #1;
      rst = 0;
      check("rst-mid ready", 32'(rdy0), 32'd1);
      check("rst-mid WE_N", 32'(wen0), 32'd1);
      check("rst-mid OE_N", 32'(oen0), 32'd1);
      check("rst-mid DQ_oe", 32'(oe0), 32'd0);
      check("rst-mid mem[2]", 32'(mem0[2]), 32'h00001234);
      check("rst-mid mem[3]", 32'(mem0[3] === m3), 32'd1);
      @(posedge clk); #1;

      // WAIT_CYCLES = 1 instance: load at 1032.
      re1 = 1; addr1 = 32'd1032;
      lat = 0; got = 0;
      while (!got && lat < 40) begin
         @(posedge clk); lat++;
         @(negedge clk);
         if (rdy1) got = 1;
      end
      check("w1 latency", lat, 2*W1 + 1);
      check("w1 readData", rd1, 32'hABCD1234);
      @(posedge clk); #1;
      re1 = 0;
      @(negedge clk);
      check("w1 back to idle OE_N", 32'(oen1), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
